// File: rtl/vector_cpu_pkg.sv
// Shared types and constants for the vector memory sequencer.
// VSEQ_TIMEOUT_LIMIT only has an effect when VSEQ_TIMEOUT_EN is defined.
package vector_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } vseq_state_e;

    localparam int unsigned VSEQ_TIMEOUT_LIMIT = 16;
    localparam int unsigned VSEQ_TIMEOUT_W     = $clog2(VSEQ_TIMEOUT_LIMIT);

    // Lane-index width is $clog2(R), with a floor of one bit for single-lane builds.
    function automatic int unsigned lane_idx_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vseq_lane_counter.sv
// Lane counter for the vector memory sequencer.
// Flags when the current lane is the final beat of the transfer.
module vseq_lane_counter
    import vector_cpu_pkg::*;
#(
    parameter int unsigned R  = 6,
    parameter int unsigned LW = lane_idx_w(R)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    input  logic [LW-1:0] last_idx,
    output logic [LW-1:0] lane,
    output logic          last
);

    always_ff @(posedge clk) begin
        if (reset) begin
            lane <= '0;
        end else if (clear) begin
            lane <= '0;
        end else if (advance) begin
            lane <= lane + 1'b1;
        end
    end

    assign last = (lane == last_idx);

endmodule

// File: rtl/vector_mem_sequencer.sv
// Sequences R-lane or scalar loads/stores into byte beats on a simple memory port.
// Optional stall timeout: define VSEQ_TIMEOUT_EN to enable the sticky MemErrM watchdog.
module vector_mem_sequencer
    import vector_cpu_pkg::*;
#(
    parameter int unsigned I = 32,
    parameter int unsigned N = 8,
    parameter int unsigned R = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemWriteM,
    input  logic                MemtoRegM,
    input  logic                LDSFlagM,
    input  logic [I-1:0]        AddressM,
    input  logic [R-1:0][N-1:0] WriteDataM,
    input  logic                mem_ready,
    input  logic [N-1:0]        mem_rdata,
    output logic [I-1:0]        mem_addr,
    output logic [N-1:0]        mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    output logic [R-1:0][N-1:0] ReadDataM,
    output logic                StallM,
    output logic                DoneM,
    output logic                MemErrM
);

    localparam int unsigned LW = lane_idx_w(R);

    vseq_state_e          state, state_nxt;
    logic [I-1:0]         base_q;
    logic [R-1:0][N-1:0]  wdata_q;
    logic                 store_q;
    logic [LW-1:0]        last_q;
    logic [LW-1:0]        lane;
    logic                 last_beat;
    logic                 req;
    logic                 capture;
    logic                 beat_done;
    logic                 timeout;

    assign req = MemWriteM | MemtoRegM;

    vseq_lane_counter #(
        .R  (R),
        .LW (LW)
    ) u_lane_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (capture),
        .advance  (beat_done),
        .last_idx (last_q),
        .lane     (lane),
        .last     (last_beat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            base_q    <= '0;
            wdata_q   <= '0;
            store_q   <= 1'b0;
            last_q    <= '0;
            ReadDataM <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                base_q  <= AddressM;
                wdata_q <= WriteDataM;
                store_q <= MemWriteM;
                last_q  <= LDSFlagM ? '0 : LW'(R - 1);
            end
            if (beat_done && !store_q) begin
                ReadDataM[lane] <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        beat_done = 1'b0;
        StallM    = 1'b0;
        DoneM     = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    StallM    = 1'b1;
                    capture   = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                StallM    = 1'b1;
                mem_addr  = base_q + I'(lane);
                mem_wdata = wdata_q[lane];
                mem_we    = store_q;
                mem_re    = !store_q;
                if (mem_ready) begin
                    beat_done = 1'b1;
                    if (last_beat) begin
                        state_nxt = DONE;
                    end
                end else if (timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                DoneM     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef VSEQ_TIMEOUT_EN
    logic [VSEQ_TIMEOUT_W-1:0] tcnt;
    logic                      err_q;

    // Counts consecutive not-ready XFER cycles; the 16th such cycle aborts to DONE.
    assign timeout = (state == XFER) && !mem_ready
                     && (tcnt == VSEQ_TIMEOUT_W'(VSEQ_TIMEOUT_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state != XFER) || mem_ready) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign MemErrM = err_q;
`else
    assign timeout = 1'b0;
    assign MemErrM = 1'b0;
`endif

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: directed scenarios plus randomized ops
// against a byte-addressed memory model and an expected-lane array.
module tb_vector_mem_sequencer;

    localparam int unsigned I = 32;
    localparam int unsigned N = 8;
    localparam int unsigned R = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic                MemWriteM, MemtoRegM, LDSFlagM;
    logic [I-1:0]        AddressM;
    logic [R-1:0][N-1:0] WriteDataM;
    logic                mem_ready;
    logic [N-1:0]        mem_rdata;
    logic [I-1:0]        mem_addr;
    logic [N-1:0]        mem_wdata;
    logic                mem_we, mem_re;
    logic [R-1:0][N-1:0] ReadDataM;
    logic                StallM, DoneM, MemErrM;

    vector_mem_sequencer #(.I(I), .N(N), .R(R)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .LDSFlagM   (LDSFlagM),
        .AddressM   (AddressM),
        .WriteDataM (WriteDataM),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .DoneM      (DoneM),
        .MemErrM    (MemErrM)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [N-1:0] mem [logic [I-1:0]];
    logic [N-1:0] rd_model [R];
    logic        exp_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] mem_rd(input logic [I-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [63:0] rd_packed();
        logic [63:0] r = '0;
        for (int k = 0; k < R; k++) r[k*N +: N] = rd_model[k];
        return r;
    endfunction

    // One complete transaction; a single lane may see stall_n not-ready cycles before completing.
    task automatic do_op(input bit st, input bit ld, input bit scalar, input logic [I-1:0] addr,
                         input logic [R-1:0][N-1:0] wd, input int stall_lane, input int stall_n);
        int beats       = scalar ? 1 : R;
        bit is_st       = st;
        int lane_m      = 0;
        int cyc         = 0;
        int stalls_left = stall_n;
        int exp_lat     = beats + 1 + ((stall_lane >= 0 && stall_lane < beats) ? stall_n : 0);
        logic [I-1:0] a;
        @(negedge clk);
        MemWriteM = st; MemtoRegM = ld; LDSFlagM = scalar; AddressM = addr; WriteDataM = wd;
        mem_ready = 1'b1;
        #1;
        check("stall_on_request", 64'(StallM), 64'(1));
        @(posedge clk); #1;
        MemWriteM = 1'b0; MemtoRegM = 1'b0; LDSFlagM = 1'b0;
        cyc = 1;
        while (!DoneM && cyc < 60) begin
            a = addr + I'(lane_m);
            check("xfer_stall", 64'(StallM), 64'(1));
            check("beat_addr", 64'(mem_addr), 64'(a));
            check("beat_we", 64'(mem_we), 64'(is_st));
            check("beat_re", 64'(mem_re), 64'(!is_st));
            if (is_st && lane_m < R) check("beat_wdata", 64'(mem_wdata), 64'(wd[lane_m]));
            if (lane_m == stall_lane && stalls_left > 0) begin
                mem_ready = 1'b0;
                mem_rdata = N'($urandom);
                stalls_left--;
            end else begin
                mem_ready = 1'b1;
                if (lane_m < R) begin
                    if (is_st) mem[a] = wd[lane_m];
                    else begin
                        mem_rdata = mem_rd(a);
                        rd_model[lane_m] = mem_rdata;
                    end
                end
                lane_m++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_ready = 1'b1;
        check("done_latency", 64'(cyc), 64'(exp_lat));
        check("beats_issued", 64'(lane_m), 64'(beats));
        check("done_pulse", 64'(DoneM), 64'(1));
        check("done_stall_low", 64'(StallM), 64'(0));
        check("done_we_low", 64'(mem_we), 64'(0));
        check("done_re_low", 64'(mem_re), 64'(0));
        check("read_data", 64'(ReadDataM), rd_packed());
        check("mem_err", 64'(MemErrM), 64'(exp_err));
        @(posedge clk); #1;
        check("done_one_cycle", 64'(DoneM), 64'(0));
    endtask

    initial begin : stim
        logic [R-1:0][N-1:0] wd;
        int cyc;
        reset = 1'b1; MemWriteM = 1'b0; MemtoRegM = 1'b0; LDSFlagM = 1'b0;
        AddressM = '0; WriteDataM = '0; mem_ready = 1'b1; mem_rdata = '0;
        for (int k = 0; k < R; k++) rd_model[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 64'(StallM), 64'(0));
        check("rst_done", 64'(DoneM), 64'(0));
        check("rst_we_re", 64'({mem_we, mem_re}), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_rdata", 64'(ReadDataM), 64'(0));
        check("rst_err", 64'(MemErrM), 64'(0));
        reset = 1'b0;

        // R-lane store of 0x11..0x66 at 0x100.
        for (int k = 0; k < R; k++) wd[k] = N'(8'h11 * (k + 1));
        do_op(1'b1, 1'b0, 1'b0, 32'h100, wd, -1, 0);

        // R-lane load with two not-ready cycles before lane 3.
        for (int k = 0; k < R; k++) mem[32'h200 + k] = N'(8'hA0 + k);
        do_op(1'b0, 1'b1, 1'b0, 32'h200, wd, 3, 2);
        check("load_lanes", 64'(ReadDataM), 64'h0000_A5A4A3A2A1A0);

        // Scalar load leaves upper lanes untouched.
        mem[32'h20] = 8'h7F;
        do_op(1'b0, 1'b1, 1'b1, 32'h20, wd, -1, 0);
        check("scalar_lanes", 64'(ReadDataM), 64'h0000_A5A4A3A2A17F);

        // Store wins over load; store and read-back across the address wrap.
        for (int k = 0; k < R; k++) wd[k] = N'($urandom);
        do_op(1'b1, 1'b1, 1'b0, 32'h300, wd, 2, 1);
        do_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, wd, 1, 1);
        do_op(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, wd, -1, 0);
        check("wrap_readback", 64'(ReadDataM), 64'(wd));
        do_op(1'b1, 1'b0, 1'b1, 32'h40, wd, 0, 2);

        // Reset in XFER at lane 2 aborts the load.
        @(negedge clk);
        MemtoRegM = 1'b1; AddressM = 32'h500; mem_ready = 1'b1;
        @(posedge clk); #1;
        MemtoRegM = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_rdata = mem_rd(32'h500 + k);
            @(posedge clk); #1;
        end
        check("abort_at_lane2", 64'(mem_addr), 64'(32'h502));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < R; k++) rd_model[k] = '0;
        check("abort_stall", 64'(StallM), 64'(0));
        check("abort_strobes", 64'({mem_we, mem_re, DoneM}), 64'(0));
        check("abort_addr_wdata", 64'({mem_addr, mem_wdata}), 64'(0));
        check("abort_rdata", 64'(ReadDataM), 64'(0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("abort_no_done", 64'({DoneM, StallM}), 64'(0));
        end

`ifdef VSEQ_TIMEOUT_EN
        @(negedge clk);
        MemtoRegM = 1'b1; AddressM = 32'h600; mem_ready = 1'b0;
        @(posedge clk); #1;
        MemtoRegM = 1'b0;
        cyc = 1;
        while (!DoneM && cyc < 40) begin
            check("to_err_before", 64'(MemErrM), 64'(0));
            @(posedge clk); #1;
            cyc++;
        end
        check("to_latency", 64'(cyc), 64'(17));
        check("to_done", 64'(DoneM), 64'(1));
        check("to_err_set", 64'(MemErrM), 64'(1));
        check("to_rdata_kept", 64'(ReadDataM), rd_packed());
        mem_ready = 1'b1;
        exp_err = 1'b1;
        @(posedge clk); #1;
        check("to_err_sticky", 64'(MemErrM), 64'(1));
        do_op(1'b1, 1'b0, 1'b0, 32'h700, wd, -1, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_err = 1'b0;
        for (int k = 0; k < R; k++) rd_model[k] = '0;
        check("to_err_cleared", 64'(MemErrM), 64'(0));
`else
        do_op(1'b0, 1'b1, 1'b0, 32'h600, wd, 0, 20);
`endif

        for (int n = 0; n < 25; n++) begin
            int op = int'($urandom_range(0, 2));
            bit sc = 1'(($urandom % 2));
            logic [I-1:0] ad = (n % 5 == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 4)) : $urandom;
            for (int k = 0; k < R; k++) wd[k] = N'($urandom);
            do_op(op != 1, op != 0, sc, ad, wd,
                  int'($urandom_range(0, sc ? 0 : R - 1)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
